// File: rtl/mesi_bus_requester.sv
// MESI snoop-bus requester: turns CPU read/write requests into BusRd/BusWr/BusWB.
// Optional bus_done watchdog enabled by defining MESI_REQ_TIMEOUT_EN.
module mesi_bus_requester #(
   parameter int TAG_W          = 20,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cpu_req,
   input  logic             cpu_we,
   input  logic [31:0]      cpu_addr,
   output logic             cpu_ready,
   output logic             busy,
   input  logic [TAG_W-1:0] local_tag,
   input  logic [1:0]       local_state,
   output logic             line_we,
   output logic [1:0]       line_state_nxt,
   output logic [TAG_W-1:0] line_tag_nxt,
   output logic             bus_req,
   input  logic             bus_gnt,
   output logic [1:0]       bus_cmd,
   output logic [31:0]      bus_addr,
   input  logic             bus_shared,
   input  logic             bus_done,
   output logic             err
);

   localparam logic [1:0] ST_I = 2'b00;
   localparam logic [1:0] ST_S = 2'b01;
   localparam logic [1:0] ST_E = 2'b10;
   localparam logic [1:0] ST_M = 2'b11;

   localparam logic [1:0] CMD_RD = 2'b01;
   localparam logic [1:0] CMD_WR = 2'b10;
   localparam logic [1:0] CMD_WB = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      WB_ARB,
      WB_BUS,
      ARB,
      BUS,
      DONE
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        addr_q, addr_d;
   logic [1:0]         cmd_q, cmd_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic               gap_q, gap_d;
   logic               hit;
   logic               tmo;
   logic [TAG_W-1:0]   req_tag;
   logic [TAG_W-1:0]   addr_tag;

   assign req_tag  = cpu_addr[31 -: TAG_W];
   assign addr_tag = addr_q[31 -: TAG_W];
   assign hit      = (local_tag == req_tag) && (local_state != ST_I);

`ifdef MESI_REQ_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             in_bus;

   assign in_bus = (state_q == WB_BUS) || (state_q == BUS);
   assign tmo    = in_bus && !bus_done &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = '0;
      if (in_bus) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
`else
   logic [31:0] tmo_unused;

   assign tmo_unused = 32'(TIMEOUT_CYCLES);
   assign tmo        = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         cmd_q   <= '0;
         tag_q   <= '0;
         gap_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cmd_q   <= cmd_d;
         tag_q   <= tag_d;
         gap_q   <= gap_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cmd_d   = cmd_q;
      tag_d   = tag_q;
      gap_d   = gap_q;
      unique case (state_q)
         IDLE: begin
            if (cpu_req) begin
               addr_d = cpu_addr;
               tag_d  = local_tag;
               cmd_d  = cpu_we ? CMD_WR : CMD_RD;
               gap_d  = 1'b0;
               if (hit) begin
                  if (cpu_we && (local_state == ST_S)) state_d = ARB;
                  else                                 state_d = DONE;
               end else if (local_state == ST_M) begin
                  state_d = WB_ARB;
               end else begin
                  state_d = ARB;
               end
            end
         end
         WB_ARB: begin
            if (bus_gnt) state_d = WB_BUS;
         end
         WB_BUS: begin
            if (tmo) begin
               state_d = DONE;
            end else if (bus_done) begin
               state_d = ARB;
               gap_d   = 1'b1;
            end
         end
         ARB: begin
            // first ARB cycle after a writeback keeps bus_req low
            if (gap_q)        gap_d   = 1'b0;
            else if (bus_gnt) state_d = BUS;
         end
         BUS: begin
            if (tmo || bus_done) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      cpu_ready      = 1'b0;
      busy           = (state_q != IDLE);
      line_we        = 1'b0;
      line_state_nxt = ST_I;
      line_tag_nxt   = '0;
      bus_req        = 1'b0;
      bus_cmd        = 2'b00;
      bus_addr       = '0;
      err            = tmo;
      unique case (state_q)
         IDLE: begin
            // silent E->M upgrade on a write hit
            if (cpu_req && hit && cpu_we && (local_state == ST_E)) begin
               line_we        = 1'b1;
               line_state_nxt = ST_M;
               line_tag_nxt   = local_tag;
            end
         end
         WB_ARB: begin
            bus_req = 1'b1;
         end
         WB_BUS: begin
            bus_req  = 1'b1;
            bus_cmd  = CMD_WB;
            bus_addr = {tag_q, {(32-TAG_W){1'b0}}};
            if (bus_done) begin
               line_we        = 1'b1;
               line_state_nxt = ST_I;
               line_tag_nxt   = tag_q;
            end
         end
         ARB: begin
            bus_req = !gap_q;
         end
         BUS: begin
            bus_req  = 1'b1;
            bus_cmd  = cmd_q;
            bus_addr = addr_q;
            if (bus_done) begin
               line_we      = 1'b1;
               line_tag_nxt = addr_tag;
               if (cmd_q == CMD_RD) line_state_nxt = bus_shared ? ST_S : ST_E;
               else                 line_state_nxt = ST_M;
            end
         end
         DONE: begin
            cpu_ready = 1'b1;
         end
         default: begin
            busy = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_mesi_bus_requester.sv
// Directed bench for mesi_bus_requester: hits, misses, writeback, reset abort.
// Timeout scenario runs only when MESI_REQ_TIMEOUT_EN is defined.
module tb_mesi_bus_requester;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic        cpu_ready;
   logic        busy;
   logic [19:0] local_tag;
   logic [1:0]  local_state;
   logic        line_we;
   logic [1:0]  line_state_nxt;
   logic [19:0] line_tag_nxt;
   logic        bus_req;
   logic        bus_gnt;
   logic [1:0]  bus_cmd;
   logic [31:0] bus_addr;
   logic        bus_shared;
   logic        bus_done;
   logic        err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mesi_bus_requester #(
      .TAG_W          (20),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .cpu_req        (cpu_req),
      .cpu_we         (cpu_we),
      .cpu_addr       (cpu_addr),
      .cpu_ready      (cpu_ready),
      .busy           (busy),
      .local_tag      (local_tag),
      .local_state    (local_state),
      .line_we        (line_we),
      .line_state_nxt (line_state_nxt),
      .line_tag_nxt   (line_tag_nxt),
      .bus_req        (bus_req),
      .bus_gnt        (bus_gnt),
      .bus_cmd        (bus_cmd),
      .bus_addr       (bus_addr),
      .bus_shared     (bus_shared),
      .bus_done       (bus_done),
      .err            (err)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic read_miss(input logic shared, input logic [1:0] exp_st);
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_5000;
      local_tag = 20'h0; local_state = 2'b00;
      settle();
      chk("rm_idle_busy", busy, 0);
      tick();
      chk("rm_arb_req", bus_req, 1);
      chk("rm_arb_cmd", bus_cmd, 2'b00);
      tick();
      tick();
      bus_gnt = 1;
      tick();
      bus_gnt = 0;
      settle();
      chk("rm_bus_cmd", bus_cmd, 2'b01);
      chk("rm_bus_addr", bus_addr, 32'h0000_5000);
      chk("rm_bus_nowe", line_we, 0);
      tick();
      bus_done = 1; bus_shared = shared;
      settle();
      chk("rm_done_we", line_we, 1);
      chk("rm_done_st", line_state_nxt, exp_st);
      chk("rm_done_tag", line_tag_nxt, 20'h00005);
      chk("rm_done_rdy", cpu_ready, 0);
      tick();
      bus_done = 0; bus_shared = 0;
      settle();
      chk("rm_rdy", cpu_ready, 1);
      chk("rm_rdy_req", bus_req, 0);
      chk("rm_rdy_cmd", bus_cmd, 2'b00);
      chk("rm_rdy_we", line_we, 0);
      cpu_req = 0;
      tick();
      chk("rm_rdy_off", cpu_ready, 0);
      chk("rm_idle", busy, 0);
   endtask

   initial begin
      rst = 1; cpu_req = 0; cpu_we = 0; cpu_addr = '0;
      local_tag = '0; local_state = 2'b00;
      bus_gnt = 0; bus_shared = 0; bus_done = 0;
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_req", bus_req, 0);
      chk("rst_cmd", bus_cmd, 0);
      chk("rst_rdy", cpu_ready, 0);
      chk("rst_we", line_we, 0);
      chk("rst_err", err, 0);
      tick();
      rst = 0;
      tick();

      read_miss(1'b0, 2'b10);
      read_miss(1'b1, 2'b01);

      // write hit in S -> BusWr, then state M
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'h0000_5004;
      local_tag = 20'h00005; local_state = 2'b01;
      settle();
      chk("ws_idle_we", line_we, 0);
      tick();
      chk("ws_arb_req", bus_req, 1);
      bus_gnt = 1;
      tick();
      bus_gnt = 0;
      settle();
      chk("ws_cmd", bus_cmd, 2'b10);
      chk("ws_addr", bus_addr, 32'h0000_5004);
      bus_done = 1;
      settle();
      chk("ws_we", line_we, 1);
      chk("ws_st", line_state_nxt, 2'b11);
      chk("ws_tag", line_tag_nxt, 20'h00005);
      tick();
      bus_done = 0;
      settle();
      chk("ws_rdy", cpu_ready, 1);
      cpu_req = 0;
      tick();

      // write hit in E -> silent upgrade, no bus
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'h0000_5008;
      local_tag = 20'h00005; local_state = 2'b10;
      settle();
      chk("we_we", line_we, 1);
      chk("we_st", line_state_nxt, 2'b11);
      chk("we_tag", line_tag_nxt, 20'h00005);
      chk("we_req", bus_req, 0);
      tick();
      chk("we_rdy", cpu_ready, 1);
      chk("we_we2", line_we, 0);
      chk("we_req2", bus_req, 0);
      cpu_req = 0;
      tick();
      chk("we_idle", busy, 0);

      // write hit in M -> no line write
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'h0000_5010;
      local_tag = 20'h00005; local_state = 2'b11;
      settle();
      chk("wm_we", line_we, 0);
      tick();
      chk("wm_rdy", cpu_ready, 1);
      chk("wm_req", bus_req, 0);
      cpu_req = 0;
      tick();

      // dirty victim: BusWB then BusWr
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'h0000_5000;
      local_tag = 20'h0000A; local_state = 2'b11;
      tick();
      chk("dv_wbarb_req", bus_req, 1);
      chk("dv_wbarb_cmd", bus_cmd, 0);
      bus_gnt = 1;
      tick();
      bus_gnt = 0;
      settle();
      chk("dv_wb_cmd", bus_cmd, 2'b11);
      chk("dv_wb_addr", bus_addr, 32'h0000_A000);
      bus_done = 1;
      settle();
      chk("dv_wb_we", line_we, 1);
      chk("dv_wb_st", line_state_nxt, 2'b00);
      chk("dv_wb_tag", line_tag_nxt, 20'h0000A);
      tick();
      bus_done = 0; bus_gnt = 1;
      settle();
      chk("dv_gap_req", bus_req, 0);
      chk("dv_gap_cmd", bus_cmd, 0);
      tick();
      chk("dv_arb_req", bus_req, 1);
      chk("dv_arb_cmd", bus_cmd, 0);
      tick();
      bus_gnt = 0;
      settle();
      chk("dv_wr_cmd", bus_cmd, 2'b10);
      chk("dv_wr_addr", bus_addr, 32'h0000_5000);
      bus_done = 1;
      settle();
      chk("dv_wr_we", line_we, 1);
      chk("dv_wr_st", line_state_nxt, 2'b11);
      chk("dv_wr_tag", line_tag_nxt, 20'h00005);
      tick();
      bus_done = 0;
      settle();
      chk("dv_rdy", cpu_ready, 1);
      cpu_req = 0;
      tick();

      // reset while arbitrating
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_7000;
      local_tag = 20'h0; local_state = 2'b00;
      tick();
      chk("rs_arb_req", bus_req, 1);
      #2;
      rst = 1;
      settle();
      chk("rs_req", bus_req, 0);
      chk("rs_busy", busy, 0);
      chk("rs_rdy", cpu_ready, 0);
      chk("rs_we", line_we, 0);
      cpu_req = 0;
      tick();
      rst = 0;
      tick();
      chk("rs_idle", busy, 0);
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_7000;
      local_tag = 20'h00007; local_state = 2'b01;
      tick();
      chk("rs_hit_rdy", cpu_ready, 1);
      chk("rs_hit_req", bus_req, 0);
      chk("rs_hit_we", line_we, 0);
      cpu_req = 0;
      tick();
      chk("rs_hit_idle", busy, 0);

`ifdef MESI_REQ_TIMEOUT_EN
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_9000;
      local_tag = 20'h0; local_state = 2'b00;
      tick();
      bus_gnt = 1;
      tick();
      bus_gnt = 0;
      for (int i = 0; i < 7; i++) begin
         settle();
         chk("to_wait_err", err, 0);
         chk("to_wait_req", bus_req, 1);
         tick();
      end
      settle();
      chk("to_err", err, 1);
      chk("to_err_we", line_we, 0);
      tick();
      chk("to_rdy", cpu_ready, 1);
      chk("to_rdy_err", err, 0);
      chk("to_rdy_req", bus_req, 0);
      chk("to_rdy_we", line_we, 0);
      cpu_req = 0;
      tick();
      chk("to_idle", busy, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
